// File: rtl/wb_dual_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dual_queue_if
//  Description : Bundle between the two execute lanes / forwarding network
//                and the dual-issue writeback queue, including the two
//                register-file write ports driven by the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_dual_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    // Execute-lane results (lane 1 is the older instruction)
    logic               in1_valid;
    logic [4:0]         in1_rd;
    logic [XLEN-1:0]    in1_data;
    logic               in2_valid;
    logic [4:0]         in2_rd;
    logic [XLEN-1:0]    in2_data;
    logic               in_ready;

    // Register-file write ports
    logic               Wen1;
    logic [4:0]         Rd_addr1;
    logic [XLEN-1:0]    write_data1;
    logic               Wen2;
    logic [4:0]         Rd_addr2;
    logic [XLEN-1:0]    write_data2;

    // Occupancy and forwarding lookup
    logic [c_CNT_W-1:0] count;
    logic [4:0]         fwd_rs_addr;
    logic               fwd_hit;
    logic [XLEN-1:0]    fwd_data;

    // Upstream side: produces results and forwarding lookups
    modport master (
        output in1_valid, in1_rd, in1_data,
        output in2_valid, in2_rd, in2_data,
        output fwd_rs_addr,
        input  in_ready,
        input  Wen1, Rd_addr1, write_data1,
        input  Wen2, Rd_addr2, write_data2,
        input  count, fwd_hit, fwd_data
    );

    // Queue side
    modport slave (
        input  in1_valid, in1_rd, in1_data,
        input  in2_valid, in2_rd, in2_data,
        input  fwd_rs_addr,
        output in_ready,
        output Wen1, Rd_addr1, write_data1,
        output Wen2, Rd_addr2, write_data2,
        output count, fwd_hit, fwd_data
    );
endinterface
`default_nettype wire

// File: rtl/wb_dual_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dual_queue
//  Description : Dual-issue writeback queue in front of the 2-write-port
//                register file. Buffers up to two results per cycle in
//                program order, drops x0 writes, drains up to two entries per
//                cycle and resolves same-destination pairs (younger wins).
//                Optional store-to-read forwarding search when the macro
//                WB_FWD_EN is defined; otherwise fwd_hit/fwd_data are tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_dual_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_dual_queue_if.slave  bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    // Accept only when at least two free slots remain
    localparam logic [c_CNT_W-1:0] c_READY_MAX = c_CNT_W'(DEPTH - 2);

    // Entry storage
    logic [4:0]         r_rd   [DEPTH];
    logic [XLEN-1:0]    r_data [DEPTH];

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    // Registered write ports
    logic               r_wen1;
    logic [4:0]         r_rd1;
    logic [XLEN-1:0]    r_data1;
    logic               r_wen2;
    logic [4:0]         r_rd2;
    logic [XLEN-1:0]    r_data2;

    logic               w_ready;
    logic               w_acc1;
    logic               w_acc2;
    logic [c_PTR_W-1:0] w_slot2;
    logic [c_CNT_W-1:0] w_enq;
    logic               w_pop1;
    logic               w_pop2;
    logic [c_CNT_W-1:0] w_pop;
    logic [c_PTR_W-1:0] w_head1;
    logic               w_collide;
    logic               w_port1_en;
    logic               w_fwd_hit;
    logic [XLEN-1:0]    w_fwd_data;

    // Readiness uses only registered occupancy; a same-cycle drain earns no credit
    assign w_ready = rst_n & (r_count <= c_READY_MAX);

    // x0 results are dropped and never occupy a slot
    assign w_acc1  = w_ready & bus.in1_valid & (bus.in1_rd != 5'd0);
    assign w_acc2  = w_ready & bus.in2_valid & (bus.in2_rd != 5'd0);
    // Lane 2 lands right behind lane 1, or at the tail if lane 1 was dropped
    assign w_slot2 = w_acc1 ? r_tail + c_PTR_W'(1) : r_tail;
    assign w_enq   = c_CNT_W'(w_acc1) + c_CNT_W'(w_acc2);

    // Drain up to two entries every cycle
    assign w_pop1    = (r_count != '0);
    assign w_pop2    = (r_count >= c_CNT_W'(2));
    assign w_pop     = c_CNT_W'(w_pop1) + c_CNT_W'(w_pop2);
    assign w_head1   = r_head + c_PTR_W'(1);
    // Both entries target the same register: only the younger one writes
    assign w_collide = w_pop2 && (r_rd[r_head] == r_rd[w_head1]);
    assign w_port1_en = w_pop1 & ~w_collide;

    // Entry storage write; contents need no reset since occupancy gates use
    always_ff @(posedge clk) begin
        if (w_acc1) begin
            r_rd[r_tail]   <= bus.in1_rd;
            r_data[r_tail] <= bus.in1_data;
        end
        if (w_acc2) begin
            r_rd[w_slot2]   <= bus.in2_rd;
            r_data[w_slot2] <= bus.in2_data;
        end
    end

    // Pointer, occupancy and write-port registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_wen1  <= 1'b0;
            r_rd1   <= '0;
            r_data1 <= '0;
            r_wen2  <= 1'b0;
            r_rd2   <= '0;
            r_data2 <= '0;
        end else begin
            r_tail  <= r_tail + c_PTR_W'(w_enq);
            r_head  <= r_head + c_PTR_W'(w_pop);
            r_count <= r_count + w_enq - w_pop;
            r_wen1  <= w_port1_en;
            r_rd1   <= w_port1_en ? r_rd[r_head]   : 5'd0;
            r_data1 <= w_port1_en ? r_data[r_head] : '0;
            r_wen2  <= w_pop2;
            r_rd2   <= w_pop2 ? r_rd[w_head1]   : 5'd0;
            r_data2 <= w_pop2 ? r_data[w_head1] : '0;
        end
    end

`ifdef WB_FWD_EN
    // Search oldest to youngest so the last match (youngest) wins
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((c_CNT_W'(i) < r_count) && (bus.fwd_rs_addr != 5'd0) &&
                (r_rd[r_head + c_PTR_W'(i)] == bus.fwd_rs_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[r_head + c_PTR_W'(i)];
            end
        end
    end
`else
    logic w_fwd_unused;
    assign w_fwd_unused = ^bus.fwd_rs_addr;
    assign w_fwd_hit    = 1'b0;
    assign w_fwd_data   = '0;
`endif

    assign bus.in_ready    = w_ready;
    assign bus.Wen1        = r_wen1;
    assign bus.Rd_addr1    = r_rd1;
    assign bus.write_data1 = r_data1;
    assign bus.Wen2        = r_wen2;
    assign bus.Rd_addr2    = r_rd2;
    assign bus.write_data2 = r_data2;
    assign bus.count       = r_count;
    assign bus.fwd_hit     = w_fwd_hit;
    assign bus.fwd_data    = w_fwd_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_dual_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_dual_queue
//  Description : Self-checking bench for wb_dual_queue. A queue-based
//                reference model is compared against every output at each
//                falling edge; directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_dual_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_dual_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    wb_dual_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    logic            m_wen1, m_wen2;
    logic [4:0]      m_rd1, m_rd2;
    logic [XLEN-1:0] m_d1, m_d2;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of pending results, advanced at each rising edge
    initial begin : model
        int   sz;
        bit   rdy;
        ent_t e1, e2;
        m_wen1 = 0; m_wen2 = 0; m_rd1 = 0; m_rd2 = 0; m_d1 = 0; m_d2 = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                m_wen1 = 0; m_wen2 = 0; m_rd1 = 0; m_rd2 = 0; m_d1 = 0; m_d2 = 0;
            end else begin
                sz  = mq.size();
                rdy = (DEPTH - sz) >= 2;
                m_wen1 = 0; m_wen2 = 0; m_rd1 = 0; m_rd2 = 0; m_d1 = 0; m_d2 = 0;
                if (sz >= 2) begin
                    e1 = mq.pop_front();
                    e2 = mq.pop_front();
                    if (e1.rd != e2.rd) begin
                        m_wen1 = 1; m_rd1 = e1.rd; m_d1 = e1.data;
                    end
                    m_wen2 = 1; m_rd2 = e2.rd; m_d2 = e2.data;
                end else if (sz == 1) begin
                    e1 = mq.pop_front();
                    m_wen1 = 1; m_rd1 = e1.rd; m_d1 = e1.data;
                end
                if (rdy) begin
                    if (bus.in1_valid && bus.in1_rd != 0) begin
                        e1.rd = bus.in1_rd; e1.data = bus.in1_data; mq.push_back(e1);
                    end
                    if (bus.in2_valid && bus.in2_rd != 0) begin
                        e2.rd = bus.in2_rd; e2.data = bus.in2_data; mq.push_back(e2);
                    end
                end
            end
        end
    end

    // Compare every output against the model at each falling edge
    initial begin : compare
        bit              e_hit;
        logic [XLEN-1:0] e_fd;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_hit = 0;
                e_fd  = '0;
`ifdef WB_FWD_EN
                foreach (mq[i]) begin
                    if (bus.fwd_rs_addr != 0 && mq[i].rd == bus.fwd_rs_addr) begin
                        e_hit = 1;
                        e_fd  = mq[i].data;
                    end
                end
`endif
                chk("model Wen1",        64'(bus.Wen1),        64'(m_wen1));
                chk("model Rd_addr1",    64'(bus.Rd_addr1),    64'(m_rd1));
                chk("model write_data1", 64'(bus.write_data1), 64'(m_d1));
                chk("model Wen2",        64'(bus.Wen2),        64'(m_wen2));
                chk("model Rd_addr2",    64'(bus.Rd_addr2),    64'(m_rd2));
                chk("model write_data2", 64'(bus.write_data2), 64'(m_d2));
                chk("model count",       64'(bus.count),       64'(mq.size()));
                chk("model in_ready",    64'(bus.in_ready),
                    64'(rst_n && ((DEPTH - mq.size()) >= 2)));
                chk("model fwd_hit",     64'(bus.fwd_hit),     64'(e_hit));
                chk("model fwd_data",    64'(bus.fwd_data),    64'(e_fd));
            end
        end
    end

    task automatic set_in(input bit v1, input logic [4:0] r1, input logic [63:0] d1,
                          input bit v2, input logic [4:0] r2, input logic [63:0] d2);
        bus.in1_valid = v1; bus.in1_rd = r1; bus.in1_data = d1;
        bus.in2_valid = v2; bus.in2_rd = r2; bus.in2_data = d2;
    endtask

    task automatic idle_in();
        set_in(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        idle_in();
        bus.fwd_rs_addr = 5'd0;

        // Reset then idle
        rst_n = 0;
        tick(); tick();
        rst_n  = 1;
        chk_en = 1;
        @(negedge clk);
        chk("idle count",    64'(bus.count),       64'd0);
        chk("idle in_ready", 64'(bus.in_ready),    64'd1);
        chk("idle Wen1",     64'(bus.Wen1),        64'd0);
        chk("idle Wen2",     64'(bus.Wen2),        64'd0);
        chk("idle Rd_addr1", 64'(bus.Rd_addr1),    64'd0);
        chk("idle data2",    64'(bus.write_data2), 64'd0);
        tick();

        // Dual write
        set_in(1, 5'd5, 64'h11, 1, 5'd6, 64'h22);
        tick();
        idle_in();
        @(negedge clk);
        chk("dual count E",  64'(bus.count), 64'd2);
        chk("dual Wen1 E",   64'(bus.Wen1),  64'd0);
        tick();
        @(negedge clk);
        chk("dual Wen1",     64'(bus.Wen1),        64'd1);
        chk("dual Rd_addr1", 64'(bus.Rd_addr1),    64'd5);
        chk("dual data1",    64'(bus.write_data1), 64'h11);
        chk("dual Wen2",     64'(bus.Wen2),        64'd1);
        chk("dual Rd_addr2", 64'(bus.Rd_addr2),    64'd6);
        chk("dual data2",    64'(bus.write_data2), 64'h22);
        chk("dual count",    64'(bus.count),       64'd0);
        tick();
        @(negedge clk);
        chk("dual pulse end", 64'(bus.Wen1), 64'd0);
        tick();

        // x0 filter
        set_in(1, 5'd0, 64'hFF, 1, 5'd10, 64'hFFF);
        tick();
        idle_in();
        @(negedge clk);
        chk("x0 count", 64'(bus.count), 64'd1);
        tick();
        @(negedge clk);
        chk("x0 Wen1",     64'(bus.Wen1),        64'd1);
        chk("x0 Rd_addr1", 64'(bus.Rd_addr1),    64'd10);
        chk("x0 data1",    64'(bus.write_data1), 64'hFFF);
        chk("x0 Wen2",     64'(bus.Wen2),        64'd0);
        tick();

        // WAW collision
        set_in(1, 5'd20, 64'hA, 1, 5'd20, 64'hB);
        tick();
        idle_in();
        tick();
        @(negedge clk);
        chk("waw Wen1",     64'(bus.Wen1),        64'd0);
        chk("waw Rd_addr1", 64'(bus.Rd_addr1),    64'd0);
        chk("waw Wen2",     64'(bus.Wen2),        64'd1);
        chk("waw Rd_addr2", 64'(bus.Rd_addr2),    64'd20);
        chk("waw data2",    64'(bus.write_data2), 64'hB);
        chk("waw count",    64'(bus.count),       64'd0);
        tick();

        // Back-pressure, starting from a fresh reset
        rst_n = 0;
        tick();
        @(negedge clk);
        chk("rst in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        rst_n = 1;
        set_in(1, 5'd1, 64'h1, 1, 5'd2, 64'h2);
        tick();                                   // E0
        set_in(1, 5'd3, 64'h3, 0, 5'd0, 64'h0);
        @(negedge clk);
        chk("bp E0 count",    64'(bus.count),    64'd2);
        chk("bp E0 in_ready", 64'(bus.in_ready), 64'd1);
        tick();                                   // E1
        set_in(1, 5'd4, 64'h4, 1, 5'd5, 64'h5);
        @(negedge clk);
        chk("bp E1 count",    64'(bus.count),    64'd1);
        chk("bp E1 Rd_addr1", 64'(bus.Rd_addr1), 64'd1);
        chk("bp E1 Rd_addr2", 64'(bus.Rd_addr2), 64'd2);
        chk("bp E1 in_ready", 64'(bus.in_ready), 64'd1);
        tick();                                   // E2
        @(negedge clk);
        chk("bp E2 Rd_addr1", 64'(bus.Rd_addr1), 64'd3);
        chk("bp E2 Wen2",     64'(bus.Wen2),     64'd0);
        tick();                                   // E3
        @(negedge clk);
        chk("bp E3 Rd_addr1", 64'(bus.Rd_addr1), 64'd4);
        chk("bp E3 Rd_addr2", 64'(bus.Rd_addr2), 64'd5);
        for (int i = 0; i < 8; i++) tick();
        idle_in();
        tick(); tick(); tick();

        // Reset mid-operation discards pending entries
        set_in(1, 5'd8, 64'h88, 1, 5'd9, 64'h99);
        tick();
        idle_in();
        rst_n = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("mid-rst Wen1",  64'(bus.Wen1),  64'd0);
        chk("mid-rst Wen2",  64'(bus.Wen2),  64'd0);
        chk("mid-rst count", 64'(bus.count), 64'd0);
        tick();
        @(negedge clk);
        chk("post-rst Wen1", 64'(bus.Wen1), 64'd0);
        chk("post-rst Wen2", 64'(bus.Wen2), 64'd0);
        tick();

        // Forwarding: two entries for rd 7, younger must be returned
        bus.fwd_rs_addr = 5'd7;
        set_in(1, 5'd7, 64'h1, 1, 5'd7, 64'h2);
        tick();
        idle_in();
        @(negedge clk);
`ifdef WB_FWD_EN
        chk("fwd hit",  64'(bus.fwd_hit),  64'd1);
        chk("fwd data", 64'(bus.fwd_data), 64'h2);
`else
        chk("fwd hit",  64'(bus.fwd_hit),  64'd0);
        chk("fwd data", 64'(bus.fwd_data), 64'd0);
`endif
        tick();
        tick();

        // Forwarding: only the older lane matches
        bus.fwd_rs_addr = 5'd12;
        set_in(1, 5'd12, 64'h5, 1, 5'd13, 64'h6);
        tick();
        idle_in();
        @(negedge clk);
`ifdef WB_FWD_EN
        chk("fwd old hit",  64'(bus.fwd_hit),  64'd1);
        chk("fwd old data", 64'(bus.fwd_data), 64'h5);
`else
        chk("fwd old hit",  64'(bus.fwd_hit),  64'd0);
        chk("fwd old data", 64'(bus.fwd_data), 64'd0);
`endif
        tick();
        bus.fwd_rs_addr = 5'd0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
